// File: rtl/census_cost_80.sv
// census_cost_80
//   Producer side of the 80-way disparity argmin tree. Accepts one pair of
//   left/right census codes per valid cycle. For every pixel it emits a
//   packed vector of 80 Hamming costs, one per disparity d. The cost is
//   popcount(left[x] XOR right[x-d]). Disparities that reach back past the
//   start of the current row carry the all-ones mask value.
//
// Parameters
//   WIDTH        bits per cost entry. Must match the downstream argmin_80.
//   CENSUS_BITS  bits per census code.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   in_valid      left_census/right_census/in_sol valid this cycle
//   in_sol        start of line, qualified by in_valid
//   left_census   census code of the left pixel at column x
//   right_census  census code of the right pixel at column x
//   out_valid     out_cost valid (2 cycles after the matching in_valid)
//   out_sol       start of line, aligned with out_valid
//   out_cost      cost for disparity d at bits [WIDTH*d +: WIDTH]
//
// Handshake: in_valid qualifies the input bundle for a single cycle. There
// is no ready signal because the block accepts a pixel on every valid cycle.
// out_valid qualifies out_sol and out_cost for exactly one cycle. When
// out_valid is low, out_cost holds its last value and out_sol is 0.

module census_cost_80 #(
  parameter int WIDTH       = 6,
  parameter int CENSUS_BITS = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sol,
  input  logic [CENSUS_BITS-1:0] left_census,
  input  logic [CENSUS_BITS-1:0] right_census,
  output logic                   out_valid,
  output logic                   out_sol,
  output logic [WIDTH*80-1:0]    out_cost
);

  localparam int DISP = 80;
  localparam logic [WIDTH-1:0] MASK = '1;

  // The mask has to stay strictly above the largest real cost. Otherwise
  // argmin could pick a disparity that has no backing pixel.
  if ((2 ** WIDTH) - 1 <= CENSUS_BITS) begin : g_width_check
    $error("census_cost_80: 2^WIDTH-1 must exceed CENSUS_BITS");
  end

  // Stage-1 state
  logic [CENSUS_BITS-1:0] hist [DISP];
  logic [6:0]             fill;      // pixels of the current row seen, saturating at 80
  logic [CENSUS_BITS-1:0] left_q;
  logic                   sol_q;
  logic                   valid_q;

  logic [6:0]             fill_next;
  logic [WIDTH*DISP-1:0]  cost_next;

  function automatic logic [WIDTH-1:0] popcount(input logic [CENSUS_BITS-1:0] v);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < CENSUS_BITS; i++) begin
      s = s + WIDTH'(v[i]);
    end
    return s;
  endfunction

  // A start-of-line pixel restarts the count at 1 because its own right
  // code is already in hist[0]. The first pixel after reset also gives 1,
  // since fill starts at 0.
  always_comb begin
    fill_next = fill;
    if (in_sol) begin
      fill_next = 7'd1;
    end else if (fill != 7'(DISP)) begin
      fill_next = fill + 7'd1;
    end
  end

  // Disparities at or beyond the fill count point at older history. That
  // history belongs to a previous row or to reset, so those entries get
  // the mask value.
  always_comb begin
    cost_next = '0;
    for (int d = 0; d < DISP; d++) begin
      if (d < int'(fill)) begin
        cost_next[WIDTH*d +: WIDTH] = popcount(left_q ^ hist[d]);
      end else begin
        cost_next[WIDTH*d +: WIDTH] = MASK;
      end
    end
  end

  // Stage 1: right-code shift history, left code and row bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DISP; d++) begin
        hist[d] <= '0;
      end
      fill    <= '0;
      left_q  <= '0;
      sol_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_valid) begin
      hist[0] <= right_census;
      for (int d = 1; d < DISP; d++) begin
        hist[d] <= hist[d-1];
      end
      fill    <= fill_next;
      left_q  <= left_census;
      sol_q   <= in_sol;
      valid_q <= 1'b1;
    end else begin
      // A bubble leaves the history and fill untouched.
      sol_q   <= 1'b0;
      valid_q <= 1'b0;
    end
  end

  // Stage 2: registered cost vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_cost  <= '0;
    end else begin
      out_valid <= valid_q;
      out_sol   <= sol_q;
      if (valid_q) begin
        out_cost <= cost_next;
      end
    end
  end

endmodule
